// File: rtl/mano_ctrl_pkg.sv
// Shared encodings for the Mano basic-computer control unit: T-states, bus
// sources, ALU/E operations, opcodes and the control-word payload.
package mano_ctrl_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned SC_W   = 3;
    localparam int unsigned OPC_W  = 3;
    localparam int unsigned RR_W   = 12;

    typedef enum logic [SC_W-1:0] {
        T0, T1, T2, T3, T4, T5, T6, T7
    } t_state_e;

    typedef enum logic [2:0] {
        BUS_NONE, BUS_AR, BUS_PC, BUS_DR, BUS_AC, BUS_IR, BUS_TR, BUS_MEM
    } bus_sel_e;

    typedef enum logic [3:0] {
        ALU_NOP, ALU_AND, ALU_ADD, ALU_LDDR, ALU_CLR, ALU_CMA, ALU_SHR, ALU_SHL
    } alu_op_e;

    typedef enum logic [1:0] {
        E_HOLD, E_CLR, E_CMP, E_LOAD
    } e_op_e;

    localparam logic [OPC_W-1:0] OP_AND = 3'd0;
    localparam logic [OPC_W-1:0] OP_ADD = 3'd1;
    localparam logic [OPC_W-1:0] OP_LDA = 3'd2;
    localparam logic [OPC_W-1:0] OP_STA = 3'd3;
    localparam logic [OPC_W-1:0] OP_BUN = 3'd4;
    localparam logic [OPC_W-1:0] OP_BSA = 3'd5;
    localparam logic [OPC_W-1:0] OP_ISZ = 3'd6;
    localparam logic [OPC_W-1:0] OP_REG = 3'd7;

    typedef struct packed {
        logic     ar_ld;
        logic     ar_inc;
        logic     pc_ld;
        logic     pc_inc;
        logic     dr_ld;
        logic     dr_inc;
        logic     ac_ld;
        logic     ac_inc;
        logic     ir_ld;
        logic     tr_ld;
        logic     mem_wr;
        bus_sel_e bus;
        alu_op_e  alu;
        e_op_e    eop;
    } ctrl_s;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } rr_sel_s;

    // Highest-numbered set bit of the register-reference field wins.
    function automatic rr_sel_s rr_highest(input logic [RR_W-1:0] bits);
        rr_highest = '0;
        for (int i = 0; i < int'(RR_W); i++) begin
            if (bits[i]) begin
                rr_highest.hit = 1'b1;
                rr_highest.idx = 4'(i);
            end
        end
    endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// Sequence counter (T-state) and S run flag for the Mano control unit.
module mano_seq_counter
    import mano_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            inc,
    input  logic            halt,
    output logic [SC_W-1:0] sc,
    output logic            run
);

    t_state_e state_q, state_d;
    logic     run_q, run_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= T0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Halted machine parks at T0; T7 is never a legal state and falls back to T0.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        if (halt) begin
            run_d = 1'b0;
        end
        if (!run_q || clr || state_q == T7) begin
            state_d = T0;
        end else if (inc) begin
            state_d = t_state_e'(state_q + 3'd1);
        end
    end

    assign sc  = state_q;
    assign run = run_q;

endmodule

// File: rtl/mano_control_unit.sv
// Hardwired control unit for the Mano basic computer: decodes IR and T-state
// into datapath strobes, bus select, ALU/E operations and memory write.
module mano_control_unit
    import mano_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] ir,
    input  logic              ac_zero,
    input  logic              ac_neg,
    input  logic              e_flag,
    input  logic              dr_zero,
    output logic              ar_ld,
    output logic              ar_inc,
    output logic              pc_ld,
    output logic              pc_inc,
    output logic              dr_ld,
    output logic              dr_inc,
    output logic              ac_ld,
    output logic              ac_inc,
    output logic              ir_ld,
    output logic              tr_ld,
    output logic [2:0]        bus_sel,
    output logic [3:0]        alu_op,
    output logic [1:0]        e_op,
    output logic              mem_wr,
    output logic [SC_W-1:0]   sc,
    output logic              run
);

    localparam int unsigned OPC_LSB = ADDR_W;
    localparam int unsigned I_BIT   = ADDR_W + OPC_W;

    logic [OPC_W-1:0] opcode;
    logic             i_q;
    logic             sc_clr, sc_inc, halt;
    rr_sel_s          rr;
    ctrl_s            ctl, ctl_g;

    assign opcode = ir[OPC_LSB +: OPC_W];
    assign rr     = rr_highest(ir[RR_W-1:0]);

    mano_seq_counter u_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (sc_clr),
        .inc  (sc_inc),
        .halt (halt),
        .sc   (sc),
        .run  (run)
    );

    // Indirect bit captured at decode so T3 does not depend on IR timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_q <= 1'b0;
        end else if (run && t_state_e'(sc) == T2) begin
            i_q <= ir[I_BIT];
        end
    end

    always_comb begin
        ctl    = '0;
        sc_clr = 1'b0;
        sc_inc = 1'b0;
        halt   = 1'b0;
        case (t_state_e'(sc))
            T0: begin
                ctl.bus   = BUS_PC;
                ctl.ar_ld = 1'b1;
                sc_inc    = 1'b1;
            end
            T1: begin
                ctl.bus    = BUS_MEM;
                ctl.ir_ld  = 1'b1;
                ctl.pc_inc = 1'b1;
                sc_inc     = 1'b1;
            end
            T2: begin
                ctl.bus   = BUS_IR;
                ctl.ar_ld = 1'b1;
                sc_inc    = 1'b1;
            end
            T3: begin
                if (opcode == OP_REG) begin
                    sc_clr = 1'b1;
                    if (!i_q && rr.hit) begin
                        case (rr.idx)
                            4'd11: begin ctl.ac_ld = 1'b1; ctl.alu = ALU_CLR; end
                            4'd10: ctl.eop = E_CLR;
                            4'd9:  begin ctl.ac_ld = 1'b1; ctl.alu = ALU_CMA; end
                            4'd8:  ctl.eop = E_CMP;
                            4'd7:  begin ctl.ac_ld = 1'b1; ctl.alu = ALU_SHR; ctl.eop = E_LOAD; end
                            4'd6:  begin ctl.ac_ld = 1'b1; ctl.alu = ALU_SHL; ctl.eop = E_LOAD; end
                            4'd5:  ctl.ac_inc = 1'b1;
                            4'd4:  ctl.pc_inc = !ac_neg;
                            4'd3:  ctl.pc_inc = ac_neg;
                            4'd2:  ctl.pc_inc = ac_zero;
                            4'd1:  ctl.pc_inc = !e_flag;
                            4'd0:  halt = 1'b1;
                            default: ;
                        endcase
                    end
                end else begin
                    if (i_q) begin
                        ctl.bus   = BUS_MEM;
                        ctl.ar_ld = 1'b1;
                    end
                    sc_inc = 1'b1;
                end
            end
            T4: begin
                case (opcode)
                    OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                        ctl.bus   = BUS_MEM;
                        ctl.dr_ld = 1'b1;
                        sc_inc    = 1'b1;
                    end
                    OP_STA: begin
                        ctl.bus    = BUS_AC;
                        ctl.mem_wr = 1'b1;
                        sc_clr     = 1'b1;
                    end
                    OP_BUN: begin
                        ctl.bus   = BUS_AR;
                        ctl.pc_ld = 1'b1;
                        sc_clr    = 1'b1;
                    end
                    OP_BSA: begin
                        ctl.bus    = BUS_PC;
                        ctl.mem_wr = 1'b1;
                        ctl.ar_inc = 1'b1;
                        sc_inc     = 1'b1;
                    end
                    default: sc_clr = 1'b1;
                endcase
            end
            T5: begin
                sc_clr = 1'b1;
                case (opcode)
                    OP_AND: begin ctl.ac_ld = 1'b1; ctl.alu = ALU_AND; end
                    OP_ADD: begin ctl.ac_ld = 1'b1; ctl.alu = ALU_ADD; ctl.eop = E_LOAD; end
                    OP_LDA: begin ctl.ac_ld = 1'b1; ctl.alu = ALU_LDDR; end
                    OP_BSA: begin ctl.bus = BUS_AR; ctl.pc_ld = 1'b1; end
                    OP_ISZ: begin ctl.dr_inc = 1'b1; sc_clr = 1'b0; sc_inc = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                sc_clr = 1'b1;
                if (opcode == OP_ISZ) begin
                    ctl.bus    = BUS_DR;
                    ctl.mem_wr = 1'b1;
                    ctl.pc_inc = dr_zero;
                end
            end
            default: sc_clr = 1'b1;
        endcase
    end

    // Reset and the halted state silence every strobe.
    always_comb begin
        ctl_g = '0;
        if (run && !rst) begin
            ctl_g = ctl;
        end
    end

    assign ar_ld   = ctl_g.ar_ld;
    assign ar_inc  = ctl_g.ar_inc;
    assign pc_ld   = ctl_g.pc_ld;
    assign pc_inc  = ctl_g.pc_inc;
    assign dr_ld   = ctl_g.dr_ld;
    assign dr_inc  = ctl_g.dr_inc;
    assign ac_ld   = ctl_g.ac_ld;
    assign ac_inc  = ctl_g.ac_inc;
    assign ir_ld   = ctl_g.ir_ld;
    assign tr_ld   = ctl_g.tr_ld;
    assign mem_wr  = ctl_g.mem_wr;
    assign bus_sel = ctl_g.bus;
    assign alu_op  = ctl_g.alu;
    assign e_op    = ctl_g.eop;

endmodule

// File: doc/mano_control_unit.md
# mano_control_unit

Hardwired control unit for the Mano basic computer. Holds the sequence counter (T0–T6) and run flag, decodes IR, and drives the ld/inc strobes of the AR, PC, DR, AC, IR and TR registers plus bus select, ALU op, E-flag op and memory write. It sits between the register file/bus and memory. It is the only block that sequences the datapath.

## Interface
- `ADDR_W`, default 12: address width; IR[ADDR_W-1:0] is the address field.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ir`  in  16  current IR contents; IR[15]=I, IR[14:12]=opcode.
- `ac_zero`, `ac_neg`, `e_flag`, `dr_zero`  in  1 each  datapath status, combinational from the registers.
- `ar_ld`, `ar_inc`, `pc_ld`, `pc_inc`, `dr_ld`, `dr_inc`, `ac_ld`, `ac_inc`, `ir_ld`, `tr_ld`  out  1 each  register strobes.
- `bus_sel`  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- `alu_op`  out  4  AC ALU function.
- `e_op`  out  2  E update: 0 hold, 1 clear, 2 complement, 3 load ALU carry/shift-out.
- `mem_wr`  out  1  write bus value to M[AR].
- `sc`  out  3  current T-state (debug).
- `run`  out  1  S flag; 0 after HLT.

## Operation
- Strobes are combinational from (`sc`, `ir`, flags, `run`) and take effect at the next edge. The controller never asserts ld and inc of the same register together, because the register gives inc priority.
- Fetch:
  - T0: `bus_sel`=PC, `ar_ld`.
  - T1: `bus_sel`=mem, `ir_ld`, `pc_inc`.
- Decode, T2: `bus_sel`=IR, `ar_ld` (loads IR[11:0]). The I bit is latched internally.
- T3:
  - Opcode 7 with I=0 is register-reference. It executes here, then SC←0.
  - Opcode 7 with I=1 is I/O. It is a NOP here, then SC←0.
  - Memory-reference with I=1: `bus_sel`=mem, `ar_ld`. With I=0: no strobes.
  - SC advances to T4.
- Memory-reference:
  - AND, ADD, LDA: T4 DR←M (`bus_sel`=mem, `dr_ld`). T5 `ac_ld` with `alu_op` AND/ADD/LDDR; ADD also sets `e_op`=3. SC←0.
  - STA: T4 `bus_sel`=AC, `mem_wr`, SC←0.
  - BUN: T4 `bus_sel`=AR, `pc_ld`, SC←0.
  - BSA: T4 `bus_sel`=PC, `mem_wr`, `ar_inc`. T5 `bus_sel`=AR, `pc_ld`, SC←0.
  - ISZ: T4 DR←M. T5 `dr_inc`. T6 `bus_sel`=DR, `mem_wr`, `pc_inc` if `dr_zero`, SC←0.
- Register-reference (IR bit → action):
  - Bit 11 CLA, 10 CLE, 9 CMA, 8 CME.
  - Bit 7 CIR, 6 CIL (both `e_op`=3).
  - Bit 5 INC (`ac_inc`).
  - Bits 4–1 are SPA, SNA, SZA, SZE: `pc_inc` when the condition holds.
  - Bit 0 HLT: `run`←0.
  - If several bits are set, only the highest-numbered set bit executes. If none is set, the instruction is a NOP.
- While `run`=0: all strobes 0, `bus_sel`=0, `sc` held at 0.

## Timing
- Reset values: `sc`=0, `run`=1, latched I=0. All strobes, `mem_wr`, `bus_sel`, `alu_op` and `e_op` are 0 while `rst` is high.
- `rst` mid-instruction aborts it: the next cycle is T0 with no partial write. Reset has priority over every other event.
- Instruction latency, in cycles:
  - Register-reference: 4.
  - Direct STA/BUN: 5. Direct BSA, AND, ADD, LDA: 6. Direct ISZ: 7.
  - Indirect addressing adds nothing, because it is absorbed in T3.
- SC wraps only by explicit clear. It never counts past T6; reaching T7 is unreachable and forces SC←0.
- HLT takes effect at the end of T3, so the cycle after HLT shows `run`=0.

## Structure
- Package `mano_ctrl_pkg`: bus-select codes, `alu_op` codes (NOP, AND, ADD, LDDR, CLR, CMA, SHR, SHL), `e_op` codes, opcode constants (AND=0 … ISZ=6, REG/IO=7), T-state constants.
- Sub-module `mano_seq_counter`: 3-bit SC with sync clear/increment plus the S flip-flop. The decode logic stays in the top level.

## Test plan
- Reset, then LDA 0x050 direct (M[0x050]=0x1234), PC=0 → AR=0x050 at T3, AC=0x1234 after 6 cycles, PC=1.
- ADD indirect 0x010 (M[0x010]=0x020, M[0x020]=0xFFFF, AC=1) → AC=0, E=1, `ar_ld` from memory at T3.
- ISZ on word 0xFFFF → stored value 0x0000, `pc_inc` at T6, PC advanced by 2 in total. ISZ on 0x0004 → no skip.
- BSA 0x100 at PC=0x020 → M[0x100]=0x021, PC=0x101.
- IR=0x7004 (SZA) with AC=0 → `pc_inc` at T3. Then HLT (0x7001) → `run`=0, `sc` stuck at 0, no strobes for 20 cycles.
- Assert `rst` at T5 of an ADD → AC unchanged, next cycle `sc`=0, `run`=1, fetch restarts.
